irq_priority_controller: RTL and testbench
==========================================

# irq_priority_controller

Platform-level interrupt controller placed directly upstream of `interrupt_pipeline`. It synchronises the 16 external `irq_lines` and runs a per-source gateway state machine. It arbitrates enabled, pending sources by programmable priority against a threshold and drives the core's single external-interrupt request. A claim/complete handshake lets the trap handler retrieve the winning source ID and retire it.

## Interface
- `NUM_IRQS`, 16, number of external sources (1..31)
- `PRIO_W`, 3, priority field width; priority 0 means never interrupt
- `ID_W`, 5, source-ID width; ID = source index + 1, ID 0 = none
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `irq_lines` in NUM_IRQS: raw asynchronous interrupt sources
- `cfg_we` in 1: config write strobe
- `cfg_addr` in 8: byte address of the config register
- `cfg_wdata` in 32: config write data
- `cfg_rdata` out 32: combinational read of the register at `cfg_addr`
- `claim_req` in 1: one-cycle claim pulse from the core
- `claim_ack` out 1: registered pulse one cycle after `claim_req`
- `claim_id` out ID_W: claimed ID, valid while `claim_ack`=1
- `complete_valid` in 1: one-cycle completion pulse
- `complete_id` in ID_W: ID being retired
- `ext_irq` out 1: registered request to the pipeline

## Operation
- Register map (unmapped reads 0, unmapped writes ignored):
  - 0x00 ENABLE[NUM_IRQS-1:0]
  - 0x04 EDGE[NUM_IRQS-1:0] (1 = rising-edge source, 0 = level)
  - 0x08 THRESHOLD[PRIO_W-1:0]
  - 0x0C PENDING (read-only)
  - 0x10+4*i PRIORITY[i]
- Every input line passes a 2-flop synchroniser; edge detection compares the synchronised value with its previous-cycle value.
- Per-source gateway FSM, states IDLE, PENDING, IN_SERVICE, plus a `deferred` flag:
  - IDLE→PENDING: level source with sync line high, or edge source seeing a rising edge.
  - PENDING→IN_SERVICE: this source is claimed.
  - IN_SERVICE→IDLE: a matching complete arrives. If `deferred` is set, the transition goes to PENDING instead and `deferred` is cleared.
  - A rising edge on an edge source while in PENDING is merged and has no effect.
  - A rising edge on an edge source while in IN_SERVICE sets `deferred`.
  - Level sources ignore the line while in IN_SERVICE and re-evaluate it in IDLE.
- Arbitration: the candidate set is sources in PENDING with ENABLE=1 and PRIORITY > THRESHOLD. The winner is the highest priority; ties go to the lowest index. `best_id` is registered each cycle and `ext_irq` = (`best_id` != 0).
- Claim: on `claim_req`, the current `best_id` is latched into `claim_id`, `claim_ack` is pulsed next cycle, and that source moves to IN_SERVICE. If `best_id`=0, `claim_id`=0 and no state changes.
- Complete: ignored if the ID is 0, out of range, or not IN_SERVICE.
- Clearing ENABLE does not clear PENDING; it only masks the source.
- A claim and a complete in the same cycle for different sources are both applied. For the same source, the complete is evaluated against the pre-claim state, so it is ignored.

## Timing
- Reset values:
  - All gateways IDLE, `deferred`=0, synchronisers 0.
  - ENABLE=0, EDGE=0, THRESHOLD=0, PRIORITY=0.
  - `ext_irq`=0, `claim_ack`=0, `claim_id`=0, `best_id`=0.
- Latency, line rise (sampled edge N) to `ext_irq`=1: edge N+4 (sync 2, gateway 1, arbiter 1).
- Claim: `claim_req` at edge N gives `claim_ack`/`claim_id` valid after edge N+1. `ext_irq` reflects the updated arbitration after edge N+2.
- Config writes take effect at the next edge; arbitration sees them one cycle later.
- Asserting `rst_n` low mid-operation immediately clears all state, including IN_SERVICE and `deferred`.

## Structure
- Package `irq_ctrl_pkg`: register offsets, gateway state enum (IDLE/PENDING/IN_SERVICE), ID helper constants.
- Sub-module `irq_gateway`: one instance per source, containing the synchroniser, edge detector and gateway FSM. It takes claim/complete hits and outputs `pending`.
- The top level holds the config registers, the priority arbiter (linear scan) and the claim/ack registers.

## Test plan
- Reset, then ENABLE=0x1, PRIORITY[0]=3, THRESHOLD=0, level irq 0 high:
  - `ext_irq`=1 exactly 4 cycles after the line rises.
  - Claim returns `claim_id`=1 and `ext_irq` drops.
  - Complete(1) with the line still high brings `ext_irq` back to 1.
- PRIORITY[1]=2 and PRIORITY[5]=6, irq 1 and irq 5 raised together: first claim gives ID 6, second gives ID 2 (after complete 6).
- THRESHOLD=6 with PRIORITY[5]=6: `ext_irq` stays 0. Then THRESHOLD=5: `ext_irq`=1 two cycles after the write.
- Edge source 3 (EDGE=0x8), pulse, claim (ID 4), second pulse while in service: complete(4) leads to `ext_irq`=1 again via the deferred path. A third pulse while pending produces only one further claim.
- Claim with nothing pending gives `claim_id`=0. Complete(9) with source 8 idle has no state change. Complete(0) is ignored.
- Pull `rst_n` low while source 0 is IN_SERVICE and source 5 is PENDING: all outputs are 0 and PENDING reads 0 after release.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt priority controller: default sizes,
// register offsets, gateway state encoding and ID helpers.
package irq_ctrl_pkg;

    localparam int unsigned NUM_IRQS_DEF = 16;
    localparam int unsigned PRIO_W_DEF   = 3;
    localparam int unsigned ID_W_DEF     = 5;

    localparam logic [7:0] REG_ENABLE    = 8'h00;
    localparam logic [7:0] REG_EDGE      = 8'h04;
    localparam logic [7:0] REG_THRESHOLD = 8'h08;
    localparam logic [7:0] REG_PENDING   = 8'h0C;
    localparam logic [7:0] REG_PRIO_BASE = 8'h10;

    localparam int unsigned ID_NONE = 0;

    typedef enum logic [1:0] {
        GW_IDLE       = 2'd0,
        GW_PENDING    = 2'd1,
        GW_IN_SERVICE = 2'd2
    } gw_state_e;

    // Byte address of PRIORITY[idx]
    function automatic logic [7:0] prio_addr(input int unsigned idx);
        return 8'(32'(REG_PRIO_BASE) + (idx << 2));
    endfunction

endpackage

// File: rtl/irq_gateway.sv
// Per-source gateway: 2-flop synchroniser, rising-edge detector and the
// IDLE/PENDING/IN_SERVICE state machine with a deferred-edge flag.
// Ports: clk, rst_n, irq_line (async raw line), edge_mode (1 = edge source),
//        claim_hit / complete_hit (this source claimed / retired this cycle),
//        pending (registered, gateway is in PENDING).
module irq_gateway
    import irq_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic irq_line,
    input  logic edge_mode,
    input  logic claim_hit,
    input  logic complete_hit,
    output logic pending
);

    logic      sync1_q, sync1_d;
    logic      sync2_q, sync2_d;
    logic      prev_q, prev_d;
    gw_state_e state_q, state_d;
    logic      deferred_q, deferred_d;
    logic      pending_q, pending_d;
    logic      edge_rise_c;

    // Synchroniser and previous-value pipeline
    always_comb begin
        sync1_d     = irq_line;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        edge_rise_c = edge_mode && sync2_q && !prev_q;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
            state_q    <= GW_IDLE;
            deferred_q <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            state_q    <= state_d;
            deferred_q <= deferred_d;
            pending_q  <= pending_d;
        end
    end

    // Next state; complete is judged on the current state, so a same-cycle
    // claim of a PENDING source makes its complete a no-op.
    always_comb begin
        state_d    = state_q;
        deferred_d = deferred_q;
        case (state_q)
            GW_IDLE: begin
                if (edge_mode ? edge_rise_c : sync2_q) state_d = GW_PENDING;
            end
            GW_PENDING: begin
                if (claim_hit) state_d = GW_IN_SERVICE;
            end
            GW_IN_SERVICE: begin
                if (complete_hit) begin
                    // An edge arriving with the complete is treated as deferred
                    state_d    = (deferred_q || edge_rise_c) ? GW_PENDING : GW_IDLE;
                    deferred_d = 1'b0;
                end else if (edge_rise_c) begin
                    deferred_d = 1'b1;
                end
            end
            default: state_d = GW_IDLE;
        endcase
    end

    // Registered pending flag tracks the state register exactly
    always_comb begin
        pending_d = (state_d == GW_PENDING);
    end

    assign pending = pending_q;

endmodule

// File: rtl/irq_priority_controller.sv
// Platform interrupt controller: config registers, per-source gateways,
// linear-scan priority arbiter and the claim/complete handshake.
// Ports: clk, rst_n, irq_lines (raw sources), cfg_we/cfg_addr/cfg_wdata
//        (register write), cfg_rdata (combinational read), claim_req/claim_ack/
//        claim_id (claim handshake), complete_valid/complete_id (retire),
//        ext_irq (registered request to the core).
module irq_priority_controller
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_IRQS = NUM_IRQS_DEF,
    parameter int unsigned PRIO_W   = PRIO_W_DEF,
    parameter int unsigned ID_W     = ID_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_IRQS-1:0] irq_lines,
    input  logic                cfg_we,
    input  logic [7:0]          cfg_addr,
    input  logic [31:0]         cfg_wdata,
    output logic [31:0]         cfg_rdata,
    input  logic                claim_req,
    output logic                claim_ack,
    output logic [ID_W-1:0]     claim_id,
    input  logic                complete_valid,
    input  logic [ID_W-1:0]     complete_id,
    output logic                ext_irq
);

    logic [NUM_IRQS-1:0] enable_q, enable_d;
    logic [NUM_IRQS-1:0] edge_q, edge_d;
    logic [PRIO_W-1:0]   threshold_q, threshold_d;
    logic [PRIO_W-1:0]   prio_q [NUM_IRQS];
    logic [PRIO_W-1:0]   prio_d [NUM_IRQS];
    logic [ID_W-1:0]     best_id_q, best_id_d;
    logic [ID_W-1:0]     claim_id_q, claim_id_d;
    logic                claim_ack_q, claim_ack_d;
    logic                ext_irq_q, ext_irq_d;

    logic [NUM_IRQS-1:0] pending_vec;
    logic [NUM_IRQS-1:0] claim_hit_c;
    logic [NUM_IRQS-1:0] complete_hit_c;
    logic [PRIO_W-1:0]   best_prio_c;
    logic                unused_wdata;

    assign unused_wdata = ^cfg_wdata[31:NUM_IRQS];

    for (genvar g = 0; g < NUM_IRQS; g++) begin : g_gw
        irq_gateway u_gw (
            .clk          (clk),
            .rst_n        (rst_n),
            .irq_line     (irq_lines[g]),
            .edge_mode    (edge_q[g]),
            .claim_hit    (claim_hit_c[g]),
            .complete_hit (complete_hit_c[g]),
            .pending      (pending_vec[g])
        );
    end

    // Config register writes
    always_comb begin
        enable_d    = enable_q;
        edge_d      = edge_q;
        threshold_d = threshold_q;
        for (int unsigned i = 0; i < NUM_IRQS; i++) prio_d[i] = prio_q[i];
        if (cfg_we) begin
            if (cfg_addr == REG_ENABLE)    enable_d    = cfg_wdata[NUM_IRQS-1:0];
            if (cfg_addr == REG_EDGE)      edge_d      = cfg_wdata[NUM_IRQS-1:0];
            if (cfg_addr == REG_THRESHOLD) threshold_d = cfg_wdata[PRIO_W-1:0];
            for (int unsigned i = 0; i < NUM_IRQS; i++) begin
                if (cfg_addr == prio_addr(i)) prio_d[i] = cfg_wdata[PRIO_W-1:0];
            end
        end
    end

    // Config register reads
    always_comb begin
        cfg_rdata = '0;
        if (cfg_addr == REG_ENABLE)    cfg_rdata = 32'(enable_q);
        if (cfg_addr == REG_EDGE)      cfg_rdata = 32'(edge_q);
        if (cfg_addr == REG_THRESHOLD) cfg_rdata = 32'(threshold_q);
        if (cfg_addr == REG_PENDING)   cfg_rdata = 32'(pending_vec);
        for (int unsigned i = 0; i < NUM_IRQS; i++) begin
            if (cfg_addr == prio_addr(i)) cfg_rdata = 32'(prio_q[i]);
        end
    end

    // Arbiter: strict '>' keeps the lowest index on ties and enforces
    // PRIORITY > THRESHOLD by seeding the running best with the threshold.
    always_comb begin
        best_prio_c = threshold_q;
        best_id_d   = ID_W'(ID_NONE);
        for (int unsigned i = 0; i < NUM_IRQS; i++) begin
            if (pending_vec[i] && enable_q[i] && (prio_q[i] > best_prio_c)) begin
                best_prio_c = prio_q[i];
                best_id_d   = ID_W'(i + 1);
            end
        end
        ext_irq_d = (best_id_d != ID_W'(ID_NONE));
    end

    // Claim / complete decode; ID 0 and out-of-range IDs match no source
    always_comb begin
        claim_hit_c    = '0;
        complete_hit_c = '0;
        for (int unsigned i = 0; i < NUM_IRQS; i++) begin
            claim_hit_c[i]    = claim_req && (best_id_q == ID_W'(i + 1));
            complete_hit_c[i] = complete_valid && (complete_id == ID_W'(i + 1));
        end
        claim_ack_d = claim_req;
        claim_id_d  = claim_req ? best_id_q : ID_W'(ID_NONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q    <= '0;
            edge_q      <= '0;
            threshold_q <= '0;
            for (int unsigned i = 0; i < NUM_IRQS; i++) prio_q[i] <= '0;
            best_id_q   <= '0;
            claim_id_q  <= '0;
            claim_ack_q <= 1'b0;
            ext_irq_q   <= 1'b0;
        end else begin
            enable_q    <= enable_d;
            edge_q      <= edge_d;
            threshold_q <= threshold_d;
            for (int unsigned i = 0; i < NUM_IRQS; i++) prio_q[i] <= prio_d[i];
            best_id_q   <= best_id_d;
            claim_id_q  <= claim_id_d;
            claim_ack_q <= claim_ack_d;
            ext_irq_q   <= ext_irq_d;
        end
    end

    assign claim_ack = claim_ack_q;
    assign claim_id  = claim_id_q;
    assign ext_irq   = ext_irq_q;

endmodule

// File: tb/tb_irq_priority_controller.sv
// Bench for irq_priority_controller: directed stimulus, claim responses
// checked through a scoreboard queue by an independent monitor.
module tb_irq_priority_controller;

    logic        clk;
    logic        rst_n;
    logic [15:0] irq_lines;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        claim_req;
    logic        claim_ack;
    logic [4:0]  claim_id;
    logic        complete_valid;
    logic [4:0]  complete_id;
    logic        ext_irq;

    int checks = 0;
    int errors = 0;
    logic [4:0] sb_q[$];

    irq_priority_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .irq_lines      (irq_lines),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .cfg_rdata      (cfg_rdata),
        .claim_req      (claim_req),
        .claim_ack      (claim_ack),
        .claim_id       (claim_id),
        .complete_valid (complete_valid),
        .complete_id    (complete_id),
        .ext_irq        (ext_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every claim_ack pops one expected ID
    always @(negedge clk) begin
        if (claim_ack === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL claim_unexpected: got id %0d expected no ack", claim_id);
            end else begin
                logic [4:0] exp_id;
                exp_id = sb_q.pop_front();
                if (claim_id !== exp_id) begin
                    errors++;
                    $display("FAIL claim_id: got %0d expected %0d", claim_id, exp_id);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic [31:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        tick(1);
        cfg_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic read_chk(input string name, input logic [7:0] addr, input logic [31:0] exp);
        cfg_addr = addr;
        #1;
        chk(name, cfg_rdata, exp);
    endtask

    task automatic claim(input logic [4:0] exp_id);
        sb_q.push_back(exp_id);
        claim_req = 1'b1;
        tick(1);
        claim_req = 1'b0;
    endtask

    task automatic complete(input logic [4:0] id);
        complete_valid = 1'b1; complete_id = id;
        tick(1);
        complete_valid = 1'b0; complete_id = '0;
    endtask

    task automatic pulse(input int idx);
        irq_lines[idx] = 1'b1;
        tick(1);
        irq_lines[idx] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq_lines = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        claim_req = 1'b0; complete_valid = 1'b0; complete_id = '0;
        tick(2);
        chk("rst_ext_irq", 32'(ext_irq), 0);
        chk("rst_claim_ack", 32'(claim_ack), 0);
        chk("rst_claim_id", 32'(claim_id), 0);
        rst_n = 1'b1;
        tick(1);
        read_chk("rst_enable", 8'h00, 0);

        // Level source 0: latency, claim, complete with line still high
        cfg_write(8'h00, 32'h1);
        cfg_write(8'h10, 32'd3);
        cfg_write(8'h08, 32'd0);
        irq_lines[0] = 1'b1;
        tick(3);
        chk("lat_3cyc", 32'(ext_irq), 0);
        tick(1);
        chk("lat_4cyc", 32'(ext_irq), 1);
        read_chk("pending0", 8'h0C, 32'h1);
        claim(5'd1);
        tick(1);
        chk("claim_drop", 32'(ext_irq), 0);
        complete(5'd1);
        tick(1);
        chk("relevel_early", 32'(ext_irq), 0);
        tick(1);
        chk("relevel", 32'(ext_irq), 1);
        irq_lines[0] = 1'b0;
        tick(3);
        claim(5'd1);
        complete(5'd1);
        tick(3);
        chk("src0_retired", 32'(ext_irq), 0);

        // Priority ordering: source 5 (prio 6) before source 1 (prio 2)
        cfg_write(8'h14, 32'd2);
        cfg_write(8'h24, 32'd6);
        cfg_write(8'h00, 32'h23);
        read_chk("prio5_rd", 8'h24, 32'd6);
        cfg_write(8'h50, 32'd7);
        read_chk("unmapped_rd", 8'h50, 0);
        irq_lines[1] = 1'b1; irq_lines[5] = 1'b1;
        tick(5);
        chk("two_pending", 32'(ext_irq), 1);
        claim(5'd6);
        irq_lines[1] = 1'b0; irq_lines[5] = 1'b0;
        tick(3);
        complete(5'd6);
        tick(2);
        claim(5'd2);
        tick(2);
        chk("both_served", 32'(ext_irq), 0);
        complete(5'd2);
        tick(2);

        // Threshold boundary: prio must be strictly greater
        cfg_write(8'h08, 32'd6);
        irq_lines[5] = 1'b1;
        tick(6);
        chk("thresh_eq", 32'(ext_irq), 0);
        cfg_write(8'h08, 32'd5);
        chk("thresh_1cyc", 32'(ext_irq), 0);
        tick(1);
        chk("thresh_2cyc", 32'(ext_irq), 1);
        claim(5'd6);
        irq_lines[5] = 1'b0;
        tick(3);
        complete(5'd6);
        tick(2);
        cfg_write(8'h08, 32'd0);

        // Edge source 3: deferred and merged edges
        cfg_write(8'h04, 32'h8);
        cfg_write(8'h1C, 32'd4);
        cfg_write(8'h00, 32'h29);
        pulse(3);
        tick(3);
        chk("edge_pend", 32'(ext_irq), 1);
        claim(5'd4);
        tick(1);
        chk("edge_claimed", 32'(ext_irq), 0);
        pulse(3);
        tick(3);
        chk("edge_deferred_quiet", 32'(ext_irq), 0);
        complete(5'd4);
        tick(1);
        chk("edge_deferred_repend", 32'(ext_irq), 1);
        pulse(3);
        tick(3);
        chk("edge_merged", 32'(ext_irq), 1);
        claim(5'd4);
        tick(1);
        chk("edge_claim2", 32'(ext_irq), 0);
        complete(5'd4);
        tick(3);
        chk("edge_no_extra", 32'(ext_irq), 0);
        claim(5'd0);

        // Bad completes must not release an in-service source
        irq_lines[0] = 1'b1;
        tick(4);
        chk("src0_again", 32'(ext_irq), 1);
        claim(5'd1);
        complete(5'd0);
        complete(5'd9);
        complete(5'd17);
        tick(2);
        chk("bad_complete", 32'(ext_irq), 0);
        read_chk("bad_complete_pend", 8'h0C, 0);

        // Reset mid-operation: source 0 in service, source 5 pending
        irq_lines[5] = 1'b1;
        tick(4);
        chk("pre_rst_irq", 32'(ext_irq), 1);
        read_chk("pre_rst_pend", 8'h0C, 32'h20);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_irq", 32'(ext_irq), 0);
        chk("mid_rst_ack", 32'(claim_ack), 0);
        chk("mid_rst_id", 32'(claim_id), 0);
        read_chk("mid_rst_pend", 8'h0C, 0);
        irq_lines = '0;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        read_chk("post_rst_pend", 8'h0C, 0);
        read_chk("post_rst_enable", 8'h00, 0);
        chk("post_rst_irq", 32'(ext_irq), 0);

        tick(2);
        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
